// File: rtl/relay_memory_ctrl.sv
// rtl/relay_memory_ctrl.sv - single-port word memory with streamed preload, host read/write and low-address write protection
module relay_memory_ctrl #(
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 8,
  parameter int ROM_TOP = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_start,
  input  logic              load_valid,
  input  logic [DATA_W-1:0] load_data,
  output logic              load_ready,
  output logic              load_done,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              mem_ack,
  output logic              wp_err,
  output logic              busy
);

  localparam int DEPTH = 1 << ADDR_W;
  // One extra bit so ROM_TOP = DEPTH (whole array protected) is representable.
  localparam logic [ADDR_W:0] ROM_LIMIT = (ADDR_W + 1)'(ROM_TOP);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [ADDR_W-1:0] load_ptr;
  logic [ADDR_W-1:0] host_addr;
  logic              load_accept;
  logic              host_read;
  logic              host_write;
  logic              host_wp;
  logic [DATA_W-1:0] mem [0:DEPTH-1];

  assign host_addr = addr[ADDR_W-1:0];
  assign host_wp   = ({1'b0, host_addr} < ROM_LIMIT);

  wire unused_addr_hi = &{1'b0, addr[15:ADDR_W]};

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (load_start) state_nxt = LOAD;
      LOAD:    if (load_valid && (&load_ptr)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Reset gates every strobe so nothing is written in a reset cycle.
  always_comb begin
    busy        = 1'b0;
    load_ready  = 1'b0;
    load_accept = 1'b0;
    host_read   = 1'b0;
    host_write  = 1'b0;
    if (!reset) begin
      case (state)
        LOAD: begin
          busy        = 1'b1;
          load_ready  = 1'b1;
          load_accept = load_valid;
        end
        default: begin
          if (!load_start) begin
            host_read  = mem_read;
            host_write = mem_write && !mem_read;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      load_ptr    <= '0;
      load_done   <= 1'b0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      mem_ack     <= 1'b0;
      wp_err      <= 1'b0;
    end else begin
      if (state == IDLE && load_start) load_ptr <= '0;
      else if (load_accept)            load_ptr <= load_ptr + 1'b1;
      load_done   <= load_accept && (&load_ptr);
      rdata_valid <= host_read;
      if (host_read) rdata <= mem[host_addr];
      mem_ack     <= host_write && !host_wp;
      wp_err      <= host_write && host_wp;
    end
  end

  // Contents survive reset; preload bypasses write protection.
  always_ff @(posedge clk) begin
    if (load_accept)                mem[load_ptr]  <= load_data;
    else if (host_write && !host_wp) mem[host_addr] <= wdata;
  end

endmodule

// File: tb/tb_relay_memory_ctrl.sv
// tb/tb_relay_memory_ctrl.sv - directed self-checking bench for relay_memory_ctrl (ADDR_W=4, DATA_W=8, ROM_TOP=4)
module tb_relay_memory_ctrl;

  logic        clk = 1'b0;
  logic        reset, load_start, load_valid, mem_read, mem_write;
  logic [7:0]  load_data, wdata, rdata;
  logic [15:0] addr;
  logic        load_ready, load_done, rdata_valid, mem_ack, wp_err, busy;

  int n_cmp = 0;
  int n_err = 0;

  relay_memory_ctrl #(.ADDR_W(4), .DATA_W(8), .ROM_TOP(4)) dut (
    .clk(clk), .reset(reset), .load_start(load_start), .load_valid(load_valid),
    .load_data(load_data), .load_ready(load_ready), .load_done(load_done),
    .mem_read(mem_read), .mem_write(mem_write), .addr(addr), .wdata(wdata),
    .rdata(rdata), .rdata_valid(rdata_valid), .mem_ack(mem_ack),
    .wp_err(wp_err), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    load_start = 0; load_valid = 0; load_data = 0;
    mem_read = 0; mem_write = 0; addr = 0; wdata = 0;
  endtask

  initial begin
    int k;
    reset = 1;
    idle_inputs();
    step(); step();
    check("rst_busy", busy, 0);
    check("rst_load_ready", load_ready, 0);
    check("rst_load_done", load_done, 0);
    check("rst_rdata", rdata, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_mem_ack", mem_ack, 0);
    check("rst_wp_err", wp_err, 0);
    reset = 0;

    // Preload 0x10..0x1F, load_valid low every third cycle.
    load_start = 1;
    step();
    load_start = 0;
    check("load_busy", busy, 1);
    check("load_ready", load_ready, 1);
    k = 0;
    for (int c = 0; c < 100 && k < 16; c++) begin
      load_valid = (c % 3 != 2);
      load_data  = 8'h10 + 8'(k);
      check("load_busy_cyc", busy, 1);
      step();
      if (load_valid) k++;
      if (k < 16) check("load_done_early", load_done, 0);
    end
    check("load_count", k, 16);
    load_valid = 0;
    check("load_done_pulse", load_done, 1);
    check("load_busy_after", busy, 0);
    step();
    check("load_done_single", load_done, 0);

    for (int i = 0; i < 16; i++) begin
      mem_read = 1; addr = 16'(i);
      step();
      check("pre_rv", rdata_valid, 1);
      check("pre_rdata", rdata, 32'h10 + i);
    end
    mem_read = 0;
    step();
    check("rv_drop", rdata_valid, 0);
    check("rdata_hold", rdata, 8'h1F);

    // Protected write at 2, then boundary 3 / 4, then unprotected 9.
    mem_write = 1; addr = 16'h0002; wdata = 8'hAA;
    step();
    check("wp2_err", wp_err, 1);
    check("wp2_ack", mem_ack, 0);
    mem_write = 0; mem_read = 1;
    step();
    check("wp2_rdata", rdata, 8'h12);
    check("wp2_werr_clr", wp_err, 0);
    mem_read = 0; mem_write = 1; addr = 16'h0003; wdata = 8'h5A;
    step();
    check("wp3_err", wp_err, 1);
    addr = 16'h0004; wdata = 8'h5B;
    step();
    check("wp4_ack", mem_ack, 1);
    check("wp4_err", wp_err, 0);
    mem_write = 0; mem_read = 1; addr = 16'h0003;
    step();
    check("wp3_rdata", rdata, 8'h13);
    addr = 16'h0004;
    step();
    check("wp4_rdata", rdata, 8'h5B);
    mem_read = 0; mem_write = 1; addr = 16'h0009; wdata = 8'hBB;
    step();
    check("w9_ack", mem_ack, 1);
    check("w9_err", wp_err, 0);
    mem_write = 0; mem_read = 1;
    step();
    check("w9_rdata", rdata, 8'hBB);

    // Read and write together act as a read.
    mem_read = 1; mem_write = 1; addr = 16'h0005; wdata = 8'h77;
    step();
    check("rw_rv", rdata_valid, 1);
    check("rw_rdata", rdata, 8'h15);
    check("rw_ack", mem_ack, 0);
    mem_write = 0;
    step();
    check("rw_mem5", rdata, 8'h15);

    // Upper address bits ignored; read right after write sees new data.
    mem_read = 0; mem_write = 1; addr = 16'hFFF7; wdata = 8'hC3;
    step();
    check("w7_ack", mem_ack, 1);
    mem_write = 0; mem_read = 1; addr = 16'h0007;
    step();
    check("w7_rdata", rdata, 8'hC3);
    check("w7_rv", rdata_valid, 1);
    mem_read = 0;
    step();

    // Abort a preload after 6 words; host reads during LOAD are ignored.
    load_start = 1;
    step();
    load_start = 0;
    for (int i = 0; i < 6; i++) begin
      load_valid = 1; load_data = 8'h40 + 8'(i);
      mem_read = 1; addr = 16'h0000;
      step();
      check("load_no_rv", rdata_valid, 0);
      check("load_no_done", load_done, 0);
    end
    mem_read = 0;
    reset = 1; load_data = 8'hEE;
    #1;
    check("abort_busy_in_rst", busy, 0);
    step();
    reset = 0; load_valid = 0;
    check("abort_busy", busy, 0);
    check("abort_ready", load_ready, 0);
    check("abort_done", load_done, 0);
    check("abort_rdata", rdata, 0);
    step();
    check("abort_done2", load_done, 0);
    for (int i = 0; i < 7; i++) begin
      mem_read = 1; addr = 16'(i);
      step();
      check("abort_rdata_i", rdata, (i < 6) ? 32'h40 + i : 32'h16);
    end
    mem_read = 0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
